// File: rtl/vc_sw_arbiter_6.sv
// Six-VC switch-allocation arbiter: round-robin grant on head flits, held until the tail
// flit leaves, with a per-VC downstream credit counter gating every transfer.
module vc_sw_arbiter_6 #(
    parameter int CREDIT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] req,
    input  logic [5:0] head,
    input  logic [5:0] tail,
    input  logic [5:0] credit_ret,
    output logic [5:0] mux_sel,
    output logic [5:0] pop,
    output logic       credit_err
);
    localparam logic [3:0] CNT_MAX = 4'(CREDIT_DEPTH);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t     state_reg, state_next;
    logic [5:0] mux_sel_reg, mux_sel_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [3:0] cnt_reg  [6];
    logic [3:0] cnt_next [6];
    logic       credit_err_reg;
    logic [5:0] fire;
    logic [5:0] elig;
    logic [5:0] ret_ovf;
    logic       found;
    logic [3:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_vc
            logic has_credit;
            logic full;
            logic dec;
            logic inc;
            assign has_credit   = (cnt_reg[gi] != 4'd0);
            assign full         = (cnt_reg[gi] == CNT_MAX);
            assign fire[gi]     = mux_sel_reg[gi] & req[gi] & has_credit;
            assign elig[gi]     = req[gi] & head[gi] & has_credit;
            // A simultaneous transfer and credit return cancel out, even at full count.
            assign dec          = fire[gi] & ~credit_ret[gi];
            assign inc          = credit_ret[gi] & ~fire[gi] & ~full;
            assign ret_ovf[gi]  = credit_ret[gi] & ~fire[gi] & full;
            assign cnt_next[gi] = dec ? (cnt_reg[gi] - 4'd1) :
                                  inc ? (cnt_reg[gi] + 4'd1) : cnt_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            mux_sel_reg    <= '0;
            ptr_reg        <= 3'd5;
            credit_err_reg <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                cnt_reg[i] <= CNT_MAX;
            end
        end else begin
            state_reg      <= state_next;
            mux_sel_reg    <= mux_sel_next;
            ptr_reg        <= ptr_next;
            credit_err_reg <= credit_err_reg | (|ret_ovf);
            for (int i = 0; i < 6; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        mux_sel_next = mux_sel_reg;
        ptr_next     = ptr_reg;
        found        = 1'b0;
        cand         = 4'd0;
        case (state_reg)
            IDLE: begin
                mux_sel_next = '0;
                // Circular search starting one past the last winner.
                for (int k = 1; k <= 6; k++) begin
                    cand = {1'b0, ptr_reg} + 4'(k);
                    if (cand >= 4'd6) begin
                        cand = cand - 4'd6;
                    end
                    if (!found && elig[cand[2:0]]) begin
                        found    = 1'b1;
                        ptr_next = cand[2:0];
                    end
                end
                if (found) begin
                    mux_sel_next = 6'd1 << ptr_next;
                    state_next   = LOCKED;
                end
            end
            LOCKED: begin
                if (|(fire & tail)) begin
                    mux_sel_next = '0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mux_sel    = mux_sel_reg;
    assign pop        = fire;
    assign credit_err = credit_err_reg;
endmodule

// File: tb/tb_vc_sw_arbiter_6.sv
// Directed bench for vc_sw_arbiter_6: expected pops are queued as each phase is set up and
// consumed as the DUT strobes pop; registered state is checked at fixed points.
module tb_vc_sw_arbiter_6;
    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] req, head, tail, credit_ret;
    logic [5:0] mux_sel, pop;
    logic       credit_err;

    typedef struct {
        int         stamp;
        logic [5:0] vec;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    vc_sw_arbiter_6 #(.CREDIT_DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .head       (head),
        .tail       (tail),
        .credit_ret (credit_ret),
        .mux_sel    (mux_sel),
        .pop        (pop),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] r, input logic [5:0] h, input logic [5:0] t,
                         input logic [5:0] c);
        req        = r;
        head       = h;
        tail       = t;
        credit_ret = c;
    endtask

    task automatic push(input int stamp, input logic [5:0] vec);
        exp_t e;
        e.stamp = stamp;
        e.vec   = vec;
        sb.push_back(e);
    endtask

    // Any nonzero pop must match the oldest queued expectation, both vector and cycle.
    task automatic sample(input int k, input string tag);
        exp_t e;
        if (pop !== 6'd0) begin
            if (sb.size() == 0) begin
                chk({tag, "_extra_pop"}, 32'(pop), 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_pop_vec"}, 32'(pop), 32'(e.vec));
                chk({tag, "_pop_cycle"}, k, e.stamp);
            end
        end
    endtask

    task automatic chk_cnt_all(input string tag, input logic [3:0] exp);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i), 32'(dut.cnt_reg[i]), 32'(exp));
        end
    endtask

    always @(negedge clk) begin
        #3;
        chk("onehot_mux_sel", 32'($onehot0(mux_sel)), 32'd1);
        chk("onehot_pop", 32'($onehot0(pop)), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int flit;
        bit done4;

        // Reset and first arbitration after release.
        rstn = 1'b1;
        drive(6'd0, 6'd0, 6'd0, 6'd0);
        #2 rstn = 1'b0;
        @(negedge clk); #1;
        chk("rst_mux_sel", 32'(mux_sel), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_credit_err", 32'(credit_err), 32'd0);
        chk_cnt_all("rst", 4'd4);
        drive(6'b100001, 6'b100001, 6'b100001, 6'd0);
        #1 chk("rst_hold_pop", 32'(pop), 32'd0);
        @(negedge clk); rstn = 1'b1; #1;
        chk("a_release_mux", 32'(mux_sel), 32'd0);
        @(negedge clk); #1;
        chk("a_grant_vc0", 32'(mux_sel), 32'b000001);
        chk("a_pop_vc0", 32'(pop), 32'b000001);
        @(negedge clk); drive(6'b100000, 6'b100000, 6'b100000, 6'd0); #1;
        chk("a_gap_mux", 32'(mux_sel), 32'd0);
        chk("a_gap_pop", 32'(pop), 32'd0);
        @(negedge clk); #1;
        chk("a_grant_vc5", 32'(mux_sel), 32'b100000);
        chk("a_pop_vc5", 32'(pop), 32'b100000);
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'b100001); #1;
        chk("a_idle_mux", 32'(mux_sel), 32'd0);
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'd0); #1;
        chk_cnt_all("a_restore", 4'd4);

        // All six VCs sending single-flit packets: round robin, one idle cycle between.
        for (int j = 0; j < 7; j++) push(1 + 2 * j, 6'd1 << (j % 6));
        for (int k = 0; k < 14; k++) begin
            @(negedge clk); drive(6'h3f, 6'h3f, 6'h3f, 6'd0); #1;
            sample(k, "rr");
        end
        chk("rr_drain", sb.size(), 0);
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'h3f);
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'b000001);
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'd0); #1;
        chk_cnt_all("rr_restore", 4'd4);
        chk("rr_credit_err", 32'(credit_err), 32'd0);

        // VC2 six-flit packet against four credits, then single credit pulses.
        push(1, 6'b000100); push(2, 6'b000100); push(3, 6'b000100);
        push(4, 6'b000100); push(7, 6'b000100); push(10, 6'b000100);
        flit = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive((flit < 6) ? 6'b000100 : 6'd0, (flit == 0) ? 6'b000100 : 6'd0,
                  (flit == 5) ? 6'b000100 : 6'd0,
                  (k == 6 || k == 9) ? 6'b000100 : 6'd0);
            #1;
            sample(k, "cr");
            if (k == 5 || k == 8) begin
                chk($sformatf("cr_stall_mux_k%0d", k), 32'(mux_sel), 32'b000100);
                chk($sformatf("cr_stall_pop_k%0d", k), 32'(pop), 32'd0);
            end
            if (k == 11) chk("cr_release_mux", 32'(mux_sel), 32'd0);
            if (pop[2]) flit++;
        end
        chk("cr_drain", sb.size(), 0);
        chk("cr_cnt2_empty", 32'(dut.cnt_reg[2]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'b000100);
        end
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'd0); #1;
        chk("cr_cnt2_back", 32'(dut.cnt_reg[2]), 32'd4);
        chk("cr_credit_err", 32'(credit_err), 32'd0);

        // VC3: fire with a simultaneous credit return, then a return at full count.
        push(1, 6'b001000);
        @(negedge clk); drive(6'b001000, 6'b001000, 6'b001000, 6'd0); #1;
        sample(0, "ce");
        @(negedge clk); drive(6'b001000, 6'b001000, 6'b001000, 6'b001000); #1;
        sample(1, "ce");
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'b001000); #1;
        chk("ce_cnt3_same", 32'(dut.cnt_reg[3]), 32'd4);
        chk("ce_err_before", 32'(credit_err), 32'd0);
        chk("ce_mux_idle", 32'(mux_sel), 32'd0);
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'd0); #1;
        chk("ce_cnt3_full", 32'(dut.cnt_reg[3]), 32'd4);
        chk("ce_err_set", 32'(credit_err), 32'd1);
        @(negedge clk); #1;
        chk("ce_err_sticky", 32'(credit_err), 32'd1);
        chk("ce_drain", sb.size(), 0);

        // Locked on VC1 while VC4 raises a head flit.
        push(1, 6'b000010); push(2, 6'b000010); push(3, 6'b000010); push(5, 6'b010000);
        flit  = 0;
        done4 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            logic [5:0] r, h, t;
            r = '0; h = '0; t = '0;
            if (flit < 3) begin
                r[1] = 1'b1;
                h[1] = (flit == 0);
                t[1] = (flit == 2);
            end
            if (k >= 1 && !done4) begin
                r[4] = 1'b1; h[4] = 1'b1; t[4] = 1'b1;
            end
            @(negedge clk); drive(r, h, t, 6'd0); #1;
            sample(k, "lk");
            if (k >= 1 && k <= 3) chk($sformatf("lk_hold_mux_k%0d", k), 32'(mux_sel), 32'b000010);
            if (k == 4) chk("lk_gap_mux", 32'(mux_sel), 32'd0);
            if (pop[1]) flit++;
            if (pop[4]) done4 = 1'b1;
        end
        chk("lk_drain", sb.size(), 0);

        // Reset asserted while locked on VC3, then VC0 regains top priority.
        push(1, 6'b001000); push(2, 6'b001000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(6'b001000, 6'b001000, 6'd0, 6'd0); #1;
            sample(k, "rl");
            if (k >= 1) chk($sformatf("rl_lock_mux_k%0d", k), 32'(mux_sel), 32'b001000);
        end
        chk("rl_drain", sb.size(), 0);
        #1 rstn = 1'b0;
        #1;
        chk("rl_async_mux", 32'(mux_sel), 32'd0);
        chk("rl_async_pop", 32'(pop), 32'd0);
        chk("rl_async_err", 32'(credit_err), 32'd0);
        chk_cnt_all("rl_async", 4'd4);
        drive(6'b001001, 6'b001001, 6'b001001, 6'd0);
        @(negedge clk); rstn = 1'b1; #1;
        chk("rl_release_mux", 32'(mux_sel), 32'd0);
        @(negedge clk); #1;
        chk("rl_first_grant", 32'(mux_sel), 32'b000001);
        chk("rl_first_pop", 32'(pop), 32'b000001);
        @(negedge clk); drive(6'd0, 6'd0, 6'd0, 6'd0); #5;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vc_sw_arbiter_6.md
VC_SW_ARBITER_6 -- requirements
Module: vc_sw_arbiter_6

Interface
REQ-001 SHALL have parameter CREDIT_DEPTH, default 4, meaning downstream buffer slots per VC (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  6  per-VC flit present at buffer head.
REQ-005 SHALL have port head  input  6  per-VC head-flit flag of the flit at buffer head.
REQ-006 SHALL have port tail  input  6  per-VC tail-flit flag of the flit at buffer head (head=tail=1 is a single-flit packet).
REQ-007 SHALL have port credit_ret  input  6  per-VC one-cycle pulse, one slot freed downstream.
REQ-008 SHALL have port mux_sel  output  6  registered one-hot VC select, or all-zero; drives the 6:1 data/valid output mux.
REQ-009 SHALL have port pop  output  6  combinational one-hot per-VC dequeue strobe, marking the flit transferred this cycle.
REQ-010 SHALL have port credit_err  output  1  sticky flag, credit return received at full count.

Function
REQ-011 SHALL keep one 4-bit credit counter per VC, cnt[i].
REQ-012 SHALL define fire[i] = mux_sel[i] & req[i] & (cnt[i]!=0), and SHALL drive pop = fire.
REQ-013 SHALL update cnt[i] as follows: fire only -> -1; credit_ret only -> +1; both in the same cycle -> unchanged.
REQ-014 SHALL ignore credit_ret[i] (no fire) when cnt[i]==CREDIT_DEPTH, and SHALL set credit_err=1 until reset.
REQ-015 SHALL implement states IDLE and LOCKED.
REQ-016 IDLE: SHALL compute elig = req & head & (cnt!=0), per VC.
REQ-017 IDLE with elig!=0: SHALL select the first set bit of elig, searching circularly from ptr+1 (5 wraps to 0); SHALL load mux_sel with its one-hot, ptr with its index and state with LOCKED, all on the next edge.
REQ-018 IDLE with elig==0: SHALL hold mux_sel=0, hold ptr and stay in IDLE.
REQ-019 LOCKED: SHALL hold mux_sel constant; a cycle with req set but cnt==0 SHALL stall with no pop and SHALL not release the lock.
REQ-020 LOCKED with fire[ptr] & tail[ptr]: SHALL clear mux_sel to 0 and return to IDLE on the next edge (one idle cycle between packets).
REQ-021 LOCKED: head flags on non-selected VCs SHALL have no effect; no second VC is ever granted mid-packet.
REQ-022 Latency: elig visible in cycle N -> mux_sel valid in N+1 -> earliest pop in N+1.
REQ-023 SHALL assert at most one bit of mux_sel and of pop in any cycle.
REQ-024 SHALL keep the credit update running in both states, independent of the arbiter.

Reset
REQ-025 rstn low SHALL immediately, without waiting for clk, force: state=IDLE, mux_sel=0, pop=0, ptr=5, every cnt=CREDIT_DEPTH, credit_err=0.
REQ-026 Reset asserted mid-packet SHALL abandon the lock; after release, arbitration SHALL restart with VC0 at highest priority.
REQ-027 Reset release SHALL be synchronous to clk; the first arbitration decision SHALL occur on the first edge after release.

Verification
REQ-028 Bench SHALL cover reset release with req=6'b100001, head=6'b100001 -> mux_sel=000001 after 1 cycle; after VC0 tail fire, mux_sel=0 for 1 cycle, then 100000.
REQ-029 Bench SHALL cover all six VCs requesting single-flit packets continuously -> grant order 0,1,2,3,4,5,0, each 2 cycles apart.
REQ-030 Bench SHALL cover CREDIT_DEPTH=4, VC2 locked on a 6-flit packet, no credit_ret -> 4 pops, stall with mux_sel=000100; one credit_ret pulse -> exactly 1 more pop.
REQ-031 Bench SHALL cover fire and credit_ret on the same VC in the same cycle -> cnt unchanged; credit_ret at cnt=4 -> cnt stays 4 and credit_err=1.
REQ-032 Bench SHALL cover rstn low during LOCKED on VC3 -> mux_sel=0 and pop=0 before the next edge, cnt=4 on all VCs.
REQ-033 Bench SHALL cover, while locked on VC1, head asserted on VC4 -> no change to mux_sel until VC1 tail fires.
